// File: rtl/spike_queue_writer_if.sv
// Spike queue writer bus: capture/range controls in, FWFT queue head out.
//   master : controller / router side (drives capture, range, pop)
//   slave  : spike_queue_writer
//   CaptureEnable  latch SpikeBufferIn and start a scan
//   SpikeBufferIn  spike vector, bit n = neuron n spiked
//   NeuStart/End   inclusive enqueue ID range
//   QueueRead      pop request (ignored while QueueValid=0)
//   NeuronID       head-of-queue ID, QueueValid marks it valid
//   ScanComplete   scan finished and queue drained
//   SpikeCount     IDs enqueued in the current scan
interface spike_queue_writer_if #(
  parameter int NEURON_WIDTH = 11
);
  logic                         CaptureEnable;
  logic [2**NEURON_WIDTH-1:0]   SpikeBufferIn;
  logic [NEURON_WIDTH-1:0]      NeuStart;
  logic [NEURON_WIDTH-1:0]      NeuEnd;
  logic                         QueueRead;
  logic [NEURON_WIDTH-1:0]      NeuronID;
  logic                         QueueValid;
  logic                         ScanComplete;
  logic [NEURON_WIDTH:0]        SpikeCount;

  modport master (
    output CaptureEnable, SpikeBufferIn, NeuStart, NeuEnd, QueueRead,
    input  NeuronID, QueueValid, ScanComplete, SpikeCount
  );
  modport slave (
    input  CaptureEnable, SpikeBufferIn, NeuStart, NeuEnd, QueueRead,
    output NeuronID, QueueValid, ScanComplete, SpikeCount
  );
endinterface

// File: rtl/spike_queue_writer.sv
// Spike queue writer: shadows a spike vector, scans it one chunk at a time,
// and pushes in-range neuron IDs (ascending) into a first-word-fall-through
// FIFO read by the input router.
// Ports:
//   Clock  single clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    spike_queue_writer_if.slave (see interface header)
// Configuration:
//   SPIKE_COUNT_EN  defined -> saturating SpikeCount counter;
//                   undefined -> SpikeCount tied to 0.
// CHUNK_WIDTH must be a power of two >= 2 and < 2**NEURON_WIDTH.
module spike_queue_writer #(
  parameter int NEURON_WIDTH = 11,
  parameter int CHUNK_WIDTH  = 16,
  parameter int FIFO_AWIDTH  = 4
) (
  input logic                 Clock,
  input logic                 Reset,
  spike_queue_writer_if.slave bus
);
  localparam int NN    = 2**NEURON_WIDTH;
  localparam int CBW   = $clog2(CHUNK_WIDTH);
  localparam int CIW   = NEURON_WIDTH - CBW;
  localparam int DEPTH = 2**FIFO_AWIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [NN-1:0]           shadow;
  logic [CIW-1:0]          cidx;
  logic [CHUNK_WIDTH-1:0]  chunk;
  logic [CBW-1:0]          bsel;
  logic [NEURON_WIDTH-1:0] id;
  logic                    in_range, capture, push, pop, clr_bit, adv;
  logic                    full, empty;

  logic [NEURON_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AWIDTH:0]    wp, rp;   // extra MSB tells full from empty

  assign chunk    = shadow[{cidx, {CBW{1'b0}}} +: CHUNK_WIDTH];
  assign id       = {cidx, bsel};
  assign in_range = (id >= bus.NeuStart) && (id <= bus.NeuEnd);

  // lowest set bit of the current chunk (last assignment wins)
  always_comb begin
    bsel = '0;
    for (int i = CHUNK_WIDTH-1; i >= 0; i--)
      if (chunk[i]) bsel = CBW'(i);
  end

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    clr_bit   = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE, DONE:
        if (bus.CaptureEnable) begin
          capture   = 1'b1;
          state_nxt = SCAN;
        end
      SCAN:
        if (chunk == '0) begin
          if (&cidx) state_nxt = DRAIN;
          else       adv       = 1'b1;
        end else if (in_range) begin
          // full FIFO: keep the bit and retry next cycle
          if (!full) begin
            push    = 1'b1;
            clr_bit = 1'b1;
          end
        end else begin
          clr_bit = 1'b1;
        end
      DRAIN:
        if (empty) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      shadow <= '0;
      cidx   <= '0;
    end else if (capture) begin
      shadow <= bus.SpikeBufferIn;
      cidx   <= '0;
    end else begin
      if (clr_bit) shadow[id] <= 1'b0;
      if (adv)     cidx       <= cidx + 1'b1;
    end

  // FIFO
  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AWIDTH] != rp[FIFO_AWIDTH]) &&
                 (wp[FIFO_AWIDTH-1:0] == rp[FIFO_AWIDTH-1:0]);
  assign pop   = bus.QueueRead && !empty;

  always_ff @(posedge Clock)
    if (push) mem[wp[FIFO_AWIDTH-1:0]] <= id;

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end

  assign bus.QueueValid   = !empty;
  assign bus.NeuronID     = empty ? '0 : mem[rp[FIFO_AWIDTH-1:0]];
  assign bus.ScanComplete = (state == DONE);

`ifdef SPIKE_COUNT_EN
  logic [NEURON_WIDTH:0] cnt;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset)                                  cnt <= '0;
    else if (capture)                            cnt <= '0;
    else if (push && cnt != (NEURON_WIDTH+1)'(NN)) cnt <= cnt + 1'b1;
  assign bus.SpikeCount = cnt;
`else
  assign bus.SpikeCount = '0;
`endif
endmodule

// File: tb/tb_spike_queue_writer.sv
module tb_spike_queue_writer;
  localparam int NW = 11;
  localparam int NN = 2**NW;
`ifdef SPIKE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_queue_writer_if #(.NEURON_WIDTH(NW)) bus();

  spike_queue_writer #(.NEURON_WIDTH(NW), .CHUNK_WIDTH(16), .FIFO_AWIDTH(4)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int nexp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard any pop happening at the coming edge, then advance one cycle
  task automatic tick();
    if (bus.QueueValid && bus.QueueRead) begin
      if (exp_q.size() == 0) chk("extra_pop", 32'(bus.NeuronID), 32'hFFFF_FFFF);
      else begin
        chk("pop_id", 32'(bus.NeuronID), exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk); #1;
  endtask

  // reference: in-range set bits in ascending order
  task automatic start(input logic [NN-1:0] v, input int ns, input int ne);
    exp_q.delete();
    for (int n = 0; n < NN; n++)
      if (v[n] && n >= ns && n <= ne) exp_q.push_back(n);
    nexp = exp_q.size();
    bus.SpikeBufferIn = v;
    bus.NeuStart      = NW'(ns);
    bus.NeuEnd        = NW'(ne);
    bus.CaptureEnable = 1'b1;
    tick();
    bus.CaptureEnable = 1'b0;
    chk("sc_drop", 32'(bus.ScanComplete), 0);
  endtask

  task automatic finish(input bit hold, input int budget);
    int cyc = 0;
    while (!bus.ScanComplete && cyc < budget) begin
      bus.QueueRead = hold ? 1'b1 : ($urandom_range(9) < 7);
      tick();
      cyc++;
    end
    chk("scan_timeout", 32'(cyc < budget), 1);
    chk("left", exp_q.size(), 0);
    chk("qv_done", 32'(bus.QueueValid), 0);
    chk("count", 32'(bus.SpikeCount), CNT_EN ? nexp : 0);
  endtask

  initial begin
    logic [NN-1:0] v, v2;
    int cyc, qv_hits, ns, ne, nb;
    bus.CaptureEnable = 1'b0;
    bus.SpikeBufferIn = '0;
    bus.NeuStart      = '0;
    bus.NeuEnd        = '0;
    bus.QueueRead     = 1'b0;

    #2;
    chk("rst_qv", 32'(bus.QueueValid), 0);
    chk("rst_sc", 32'(bus.ScanComplete), 0);
    chk("rst_id", 32'(bus.NeuronID), 0);
    chk("rst_cnt", 32'(bus.SpikeCount), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // first-push latency
    v = '0; v[0] = 1'b1; v[5] = 1'b1;
    bus.QueueRead = 1'b0;
    start(v, 0, NN-1);
    chk("lat_qv0", 32'(bus.QueueValid), 0);
    tick();
    chk("lat_qv1", 32'(bus.QueueValid), 1);
    finish(1, 400);

    // 790, 800, 1583 in range 784..1583
    v = '0; v[790] = 1'b1; v[800] = 1'b1; v[1583] = 1'b1;
    start(v, 784, 1583);
    finish(1, 400);

    // 5 filtered out, only 900
    v = '0; v[5] = 1'b1; v[900] = 1'b1;
    start(v, 784, 1583);
    finish(1, 400);

    // 32 IDs, FIFO of 16 fills and stalls the scan
    v = '0;
    for (int n = 784; n <= 815; n++) v[n] = 1'b1;
    bus.QueueRead = 1'b0;
    start(v, 784, 1583);
    for (int i = 0; i < 200; i++) tick();
    chk("stall_qv", 32'(bus.QueueValid), 1);
    chk("stall_head", 32'(bus.NeuronID), 784);
    chk("stall_sc", 32'(bus.ScanComplete), 0);
    chk("stall_cnt", 32'(bus.SpikeCount), CNT_EN ? 16 : 0);
    finish(1, 400);

    // all-zero vector
    start('0, 0, NN-1);
    cyc = 1; qv_hits = 0;
    bus.QueueRead = 1'b1;
    while (!bus.ScanComplete && cyc < 300) begin
      if (bus.QueueValid) qv_hits++;
      tick();
      cyc++;
    end
    chk("zero_lat", 32'(cyc <= NN/16 + 3), 1);
    chk("zero_qv", qv_hits, 0);

    // reset after 3 pushes
    v = '0;
    for (int n = 0; n < 10; n++) v[n] = 1'b1;
    bus.QueueRead = 1'b0;
    start(v, 0, NN-1);
    tick(); tick(); tick();
    chk("pre_rst_cnt", 32'(bus.SpikeCount), CNT_EN ? 3 : 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_qv", 32'(bus.QueueValid), 0);
    chk("mid_rst_sc", 32'(bus.ScanComplete), 0);
    chk("mid_rst_id", 32'(bus.NeuronID), 0);
    chk("mid_rst_cnt", 32'(bus.SpikeCount), 0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    bus.QueueRead = 1'b1;
    qv_hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.QueueValid || bus.ScanComplete) qv_hits++;
      tick();
    end
    chk("post_rst_idle", qv_hits, 0);

    // CaptureEnable during SCAN is ignored
    v = '0;  v[1000] = 1'b1; v[1200] = 1'b1;
    v2 = '0; v2[100] = 1'b1; v2[1100] = 1'b1; v2[1300] = 1'b1;
    bus.QueueRead = 1'b0;
    start(v, 0, NN-1);
    tick(); tick();
    bus.SpikeBufferIn = v2;
    bus.CaptureEnable = 1'b1;
    tick();
    bus.CaptureEnable = 1'b0;
    finish(1, 400);

    // randomized scans, random ranges and random pops
    for (int t = 0; t < 10; t++) begin
      v = '0;
      nb = $urandom_range(48);
      for (int k = 0; k < nb; k++) v[$urandom_range(NN-1)] = 1'b1;
      ns = $urandom_range(NN-1);
      ne = $urandom_range(NN-1, ns);
      if (t == 0) begin ns = 0; ne = NN-1; end
      start(v, ns, ne);
      finish(0, 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
